// File: rtl/gpu_fb_word_packer_if.sv
// Pixel-in / word-out bundle between the gpu readout port, the packer and the AHB read path.
interface gpu_fb_word_packer_if #(
    parameter int CNT_W = 16
);
    logic             pix_valid;
    logic [23:0]      pix_data;
    logic             pix_ready;
    logic             frame_end;
    logic [31:0]      word_out;
    logic             word_valid;
    logic             word_read;
    logic             frame_done;
    logic [CNT_W-1:0] frame_words;

    modport master (
        output pix_valid, pix_data, frame_end, word_read,
        input  pix_ready, word_out, word_valid, frame_done, frame_words
    );

    modport slave (
        input  pix_valid, pix_data, frame_end, word_read,
        output pix_ready, word_out, word_valid, frame_done, frame_words
    );
endinterface

// File: rtl/gpu_fb_word_packer.sv
// Packs 24-bit pixels four-to-three into 32-bit words behind a small FIFO for host readout.
// Define PACK_SWAP_RB_EN to emit per-pixel bytes as b,g,r instead of r,g,b.
module gpu_fb_word_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    gpu_fb_word_packer_if.slave  bus
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {PACK, FLUSH, DONE} state_t;

    state_t             state_q, state_nx;
    logic [1:0]         ph_p0;
    logic [23:0]        residue_p0;
    logic [23:0]        residue_nx;
    logic [23:0]        bs;
    logic [31:0]        pack_word;
    logic [31:0]        push_data;
    logic               push, pop, space, accept;
    logic               latch_words, clear_frame;
    logic [31:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_nx, frame_words_q;

    // Bytes of one pixel in stream order, first byte in [7:0].
    function automatic logic [23:0] pix_bytes(input logic [23:0] p);
`ifdef PACK_SWAP_RB_EN
        return p;
`else
        return {p[7:0], p[15:8], p[23:16]};
`endif
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

    assign pop   = bus.word_read && (count_q != '0);
    assign space = (count_q != DEPTH_C) || pop;

    always_comb begin
        bs         = pix_bytes(bus.pix_data);
        pack_word  = '0;
        residue_nx = residue_p0;
        case (ph_p0)
            2'd0: residue_nx = bs;
            2'd1: begin
                pack_word  = {bs[7:0], residue_p0};
                residue_nx = {8'h00, bs[23:8]};
            end
            2'd2: begin
                pack_word  = {bs[15:0], residue_p0[15:0]};
                residue_nx = {16'h0000, bs[23:16]};
            end
            default: begin
                pack_word  = {bs, residue_p0[7:0]};
                residue_nx = '0;
            end
        endcase
    end

    always_comb begin
        state_nx    = state_q;
        accept      = 1'b0;
        push        = 1'b0;
        push_data   = '0;
        latch_words = 1'b0;
        clear_frame = 1'b0;
        case (state_q)
            PACK: begin
                accept = bus.pix_valid && space;
                if (accept && (ph_p0 != 2'd0)) begin
                    push      = 1'b1;
                    push_data = pack_word;
                end
                if (bus.frame_end)
                    state_nx = FLUSH;
            end
            FLUSH: begin
                if (ph_p0 == 2'd0) begin
                    latch_words = 1'b1;
                    state_nx    = DONE;
                end else if (space) begin
                    push        = 1'b1;
                    push_data   = {8'h00, residue_p0};
                    latch_words = 1'b1;
                    state_nx    = DONE;
                end
            end
            DONE: begin
                clear_frame = 1'b1;
                state_nx    = PACK;
            end
            default: state_nx = PACK;
        endcase
    end

    assign word_cnt_nx = sat_inc(word_cnt_q, push);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state_q <= PACK;
        else
            state_q <= state_nx;
    end

    // Stage p0: byte residue and phase carried between accepted pixels.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ph_p0      <= 2'd0;
            residue_p0 <= '0;
        end else if (clear_frame) begin
            ph_p0      <= 2'd0;
            residue_p0 <= '0;
        end else if (accept) begin
            ph_p0      <= ph_p0 + 2'd1;
            residue_p0 <= residue_nx;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_cnt_q    <= '0;
            frame_words_q <= '0;
        end else begin
            word_cnt_q <= clear_frame ? '0 : word_cnt_nx;
            if (latch_words)
                frame_words_q <= word_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= push_data;
    end

    // Stage p1: output FIFO; a pop in the same cycle frees the slot being pushed when full.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.word_valid  = (count_q != '0);
    assign bus.word_out    = bus.word_valid ? mem[rd_ptr_q] : '0;
    assign bus.pix_ready   = (state_q == PACK) && space;
    assign bus.frame_done  = (state_q == DONE);
    assign bus.frame_words = frame_words_q;
endmodule

// File: tb/tb_gpu_fb_word_packer.sv
// Scoreboard bench for gpu_fb_word_packer: a byte-queue model predicts every popped word.
module tb_gpu_fb_word_packer;
    logic tb_clk;
    logic n_rst;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_words  = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  mq[$];
    logic [31:0] mon_exp;

    gpu_fb_word_packer_if #(.CNT_W(16)) bus ();

    gpu_fb_word_packer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk   (tb_clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic model_emit();
        logic [31:0] w;
        w = {mq[3], mq[2], mq[1], mq[0]};
        repeat (4) void'(mq.pop_front());
        exp_q.push_back(w);
        model_words++;
    endtask

    task automatic model_pixel(input logic [23:0] p);
`ifdef PACK_SWAP_RB_EN
        mq.push_back(p[7:0]);
        mq.push_back(p[15:8]);
        mq.push_back(p[23:16]);
`else
        mq.push_back(p[23:16]);
        mq.push_back(p[15:8]);
        mq.push_back(p[7:0]);
`endif
        while (mq.size() >= 4) model_emit();
    endtask

    task automatic model_flush();
        if (mq.size() > 0) begin
            while (mq.size() < 4) mq.push_back(8'h00);
            model_emit();
        end
    endtask

    // Pops are compared on the falling edge before the rising edge that performs them.
    always @(negedge tb_clk) begin
        if (n_rst && bus.word_valid && bus.word_read) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL word_pop: got %08h, required no word", bus.word_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.word_out !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL word_pop: got %08h, required %08h", bus.word_out, mon_exp);
                end
            end
        end
    end

    task automatic set_read(input logic v);
        @(posedge tb_clk); #1;
        bus.word_read = v;
    endtask

    task automatic drive_pixel(input logic [23:0] p, input logic fe);
        logic ok;
        ok = 1'b0;
        @(posedge tb_clk); #1;
        bus.pix_valid = 1'b1;
        bus.pix_data  = p;
        bus.frame_end = fe;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge tb_clk);
            if (bus.pix_ready) ok = 1'b1;
            @(posedge tb_clk); #1;
            bus.frame_end = 1'b0;
        end
        bus.pix_valid = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL pix_accept: pixel %06h got not accepted, required accepted", p);
        end else begin
            model_pixel(p);
        end
        if (fe) model_flush();
    endtask

    task automatic send_frame_end();
        @(posedge tb_clk); #1;
        bus.frame_end = 1'b1;
        @(posedge tb_clk); #1;
        bus.frame_end = 1'b0;
        model_flush();
    endtask

    task automatic check_frame_done();
        int found;
        found = 0;
        for (int i = 1; i <= 12 && found == 0; i++) begin
            @(negedge tb_clk);
            if (bus.frame_done === 1'b1) found = i;
        end
        tests_run++;
        if (found != 2) begin
            tests_failed++;
            $display("FAIL frame_done_latency: got cycle %0d, required cycle 2", found);
        end
        tests_run++;
        if (bus.frame_words !== 16'(model_words)) begin
            tests_failed++;
            $display("FAIL frame_words: got %0d, required %0d", bus.frame_words, model_words);
        end
        @(negedge tb_clk);
        tests_run++;
        if (bus.frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_done_pulse: got %b, required 0", bus.frame_done);
        end
        model_words = 0;
    endtask

    task automatic drain();
        set_read(1'b1);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !bus.word_valid) break;
            @(posedge tb_clk); #1;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d words missing, required 0", exp_q.size());
        end
        @(negedge tb_clk);
        tests_run++;
        if (bus.word_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_empty: got word_valid %b, required 0", bus.word_valid);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.frame_end = 1'b0;
        bus.word_read = 1'b0;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        n_rst = 1'b1;
        @(negedge tb_clk);
        tests_run++;
        if (bus.pix_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_pix_ready: got %b, required 1", bus.pix_ready);
        end
        tests_run++;
        if (bus.word_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_word_valid: got %b, required 0", bus.word_valid);
        end
        tests_run++;
        if (bus.word_out !== 32'h0) begin
            tests_failed++; $display("FAIL rst_word_out: got %08h, required 0", bus.word_out);
        end
        tests_run++;
        if (bus.frame_done !== 1'b0) begin
            tests_failed++; $display("FAIL rst_frame_done: got %b, required 0", bus.frame_done);
        end
        tests_run++;
        if (bus.frame_words !== 16'h0) begin
            tests_failed++; $display("FAIL rst_frame_words: got %0d, required 0", bus.frame_words);
        end
    endtask

    task automatic test_four_pixels();
        set_read(1'b1);
        drive_pixel(24'h112233, 1'b0);
        drive_pixel(24'h445566, 1'b0);
        drive_pixel(24'h778899, 1'b0);
        drive_pixel(24'hAABBCC, 1'b0);
        send_frame_end();
        check_frame_done();
        drain();
    endtask

    task automatic test_short_frames();
        set_read(1'b1);
        drive_pixel(24'h112233, 1'b0);
        send_frame_end();
        check_frame_done();
        drain();
    endtask

    task automatic test_first_word();
        logic [31:0] first_exp;
`ifdef PACK_SWAP_RB_EN
        first_exp = 32'h66112233;
`else
        first_exp = 32'h44332211;
`endif
        set_read(1'b0);
        drive_pixel(24'h112233, 1'b0);
        drive_pixel(24'h445566, 1'b0);
        @(negedge tb_clk);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== first_exp) begin
            tests_failed++;
            $display("FAIL first_word: got %b/%08h, required 1/%08h", bus.word_valid, bus.word_out, first_exp);
        end
        send_frame_end();
        check_frame_done();
        drain();
    endtask

    task automatic test_frame_end_same_cycle();
        set_read(1'b1);
        drive_pixel(24'h112233, 1'b0);
        drive_pixel(24'h445566, 1'b1);
        check_frame_done();
        drain();
        drive_pixel(24'h0A0B0C, 1'b0);
        drive_pixel(24'h1A1B1C, 1'b0);
        drive_pixel(24'h2A2B2C, 1'b0);
        drive_pixel(24'h3A3B3C, 1'b1);
        check_frame_done();
        drain();
    endtask

    task automatic test_back_to_back();
        logic [23:0] px [8];
        for (int i = 0; i < 8; i++)
            px[i] = {8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3)};
        set_read(1'b0);
        for (int i = 0; i < 6; i++) drive_pixel(px[i], 1'b0);
        @(negedge tb_clk);
        tests_run++;
        if (bus.pix_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_ready_drop: got %b, required 0", bus.pix_ready);
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = px[6];
        repeat (3) begin
            @(posedge tb_clk); #1;
        end
        @(negedge tb_clk);
        tests_run++;
        if (bus.pix_ready !== 1'b0) begin
            tests_failed++; $display("FAIL bp_ready_hold: got %b, required 0", bus.pix_ready);
        end
        @(posedge tb_clk); #1;
        bus.word_read = 1'b1;
        #1;
        tests_run++;
        if (bus.pix_ready !== 1'b1) begin
            tests_failed++; $display("FAIL bp_ready_resume: got %b, required 1", bus.pix_ready);
        end
        @(posedge tb_clk); #1;
        bus.pix_valid = 1'b0;
        model_pixel(px[6]);
        drive_pixel(px[7], 1'b0);
        send_frame_end();
        check_frame_done();
        drain();
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        seen = 0;
        set_read(1'b0);
        drive_pixel(24'h112233, 1'b0);
        drive_pixel(24'h445566, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        exp_q.delete();
        mq.delete();
        model_words = 0;
        tests_run++;
        if (bus.word_valid !== 1'b0 || bus.pix_ready !== 1'b1 || bus.word_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: got valid %b ready %b out %08h, required 0 1 00000000",
                     bus.word_valid, bus.pix_ready, bus.word_out);
        end
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge tb_clk);
            if (bus.frame_done === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0 || bus.frame_words !== 16'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_done: got %0d pulses frame_words %0d, required 0 0", seen, bus.frame_words);
        end
        set_read(1'b1);
        drive_pixel(24'h112233, 1'b0);
        drive_pixel(24'h445566, 1'b0);
        drive_pixel(24'h778899, 1'b0);
        drive_pixel(24'hAABBCC, 1'b0);
        send_frame_end();
        check_frame_done();
        drain();
    endtask

    initial begin
        test_reset();
        test_four_pixels();
        test_short_frames();
        test_first_word();
        test_frame_end_same_cycle();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (2) @(posedge tb_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish");
        $fatal(1, "bench timeout");
    end
endmodule
